vga_tile_display: RTL and testbench
===================================

Name: vga_tile_display

Overview:
- Downstream consumer of the AHB-lite VGA slave's write strobe/address outputs.
- Stores one RGB444 colour per tile in a 16-row x 32-column tile buffer.
- Generates 640x480@60 VGA timing and scans the buffer out as 20x30-pixel tiles.
- Sits between the AHB-lite VGA slave and the board VGA connector; single clock domain (HCLK).

Parameters:
- PIX_DIV, 2, HCLK cycles per pixel; pixel-enable divider; 2 gives 25 MHz from 50 MHz.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels; line total 800.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; frame total 525.
- CELL_W, 20, pixels per tile horizontally.
- CELL_H, 30, lines per tile vertically.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset.
- vga_addr_v  in  4  tile row of write.
- vga_addr_h  in  5  tile column of write.
- vga_ctrl  in  32  write data; bits [11:0] = {R[3:0],G[3:0],B[3:0]}, bits [31:12] ignored.
- vga_ctrl_en  in  1  single-cycle write strobe.
- vga_hsync  out  1  horizontal sync, active low.
- vga_vsync  out  1  vertical sync, active low.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- frame_start  out  1  one-HCLK pulse at pixel (0,0) of each frame.

Behaviour:
- Reset (HRESET=1 at a clock edge):
  - Counters, tile indices and pipeline registers cleared.
  - vga_hsync=1, vga_vsync=1, rgb=0, frame_start=0.
  - Tile RAM contents are NOT cleared.
  - Reset mid-frame restarts timing at (0,0) on the first cycle after release.
- Pixel enable:
  - Divider counts 0..PIX_DIV-1; pix_en is high when the count equals PIX_DIV-1.
  - All timing and pipeline registers advance only on pix_en.
- Counters:
  - h_cnt 0..799; wraps to 0 and increments v_cnt.
  - v_cnt 0..524; wraps to 0.
  - Tile indices use no divider: sub_x 0..CELL_W-1 and col 0..31 reset at h_cnt wrap; sub_y 0..CELL_H-1 and row 0..15 reset at v_cnt wrap.
  - col/row advance when sub_x/sub_y wrap.
- Sync:
  - hsync is low for h_cnt in [656,751].
  - vsync is low for v_cnt in [490,491].
- Pipeline:
  - Stage 0: counters.
  - Stage 1: synchronous RAM read at {row,col}; active/hsync/vsync delayed one stage.
  - Stage 2: output registers.
  - Pins lag the counters by exactly 2 pix_en ticks, and sync is delayed identically so pixel/sync alignment is preserved.
  - rgb is forced to 0 when the delayed active flag = 0 (h_cnt>=640 or v_cnt>=480).
- Write port:
  - On vga_ctrl_en=1, mem[{vga_addr_v,vga_addr_h}] <= vga_ctrl[11:0] at that edge.
  - Writes are accepted every cycle regardless of pix_en or blanking; no back-pressure.
  - All 512 addresses are valid.
- Read-during-write, same address, same cycle: the read returns old data; the new data is visible from the next read.
- frame_start: a single HCLK pulse on the pix_en cycle where the counters wrap to (0,0). It is not pipeline-delayed.

Optional Feature:
- Macro VGA_CURSOR_EN.
- When defined:
  - Cursor register {row,col} latches the address of every write (reset 0,0).
  - A 6-bit frame counter increments on frame_start.
  - While frame counter bit 5 = 1, the tile at the cursor is displayed with rgb bitwise inverted; the blink period is 64 frames.
- When undefined: no cursor or frame-counter logic; output is the plain tile colour.

Decomposition:
- Package vga_pkg:
  - Timing parameter defaults and line/frame totals.
  - Sync window bounds.
  - Tile geometry constants (rows 16, cols 32).
  - The RGB444 colour typedef.
- Sub-module vga_tile_ram: 512x12 simple dual-port RAM with one synchronous write port and one synchronous read port, old-data read-during-write.
- Timing, pipeline and cursor logic stay in the top module.

Test Plan:
- Reset and timing:
  - Stimulus: assert HRESET 3 cycles, release, run 2 frames with PIX_DIV=2.
  - Response: hsync low exactly 96 pixels (192 HCLK) per 800-pixel line; vsync low exactly 2 lines per 525; frame_start period 840000 HCLK.
- Single write:
  - Stimulus: write v=3, h=5, data 0x0000_0F0A.
  - Response: pixels x=100..119, y=90..119 show r=0xF, g=0x0, b=0xA; neighbouring tiles are unchanged.
- Blanking:
  - Stimulus: write all 512 tiles 0xFFF.
  - Response: rgb=0 for every sample with h_cnt>=640 or v_cnt>=480; rgb=0xFFF in the active area.
- Read-during-write collision:
  - Stimulus: tile (0,0)=0x111; write 0x222 to (0,0) on the exact cycle its read is issued.
  - Response: that pixel shows 0x111, the next pixel of the tile shows 0x222.
- Mid-frame reset:
  - Stimulus: pulse HRESET at v_cnt=200.
  - Response: outputs at reset values next cycle; tile RAM contents retained; the next frame_start occurs 840000 HCLK after release.
- Cursor blink (VGA_CURSOR_EN):
  - Stimulus: write 0x0F0 to (15,31).
  - Response: tile at x=620..639, y=450..479 shows 0xF0F during frames 32..63 of each 64-frame cycle and 0x0F0 otherwise.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, sync window bounds, tile geometry and the
// RGB444 colour type for the VGA tile display.
package vga_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int PIX_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  // Tile geometry
  localparam int CELL_W_DEF  = 20;
  localparam int CELL_H_DEF  = 30;
  localparam int TILE_ROWS   = 16;
  localparam int TILE_COLS   = 32;
  localparam int ROW_W       = 4;
  localparam int COL_W       = 5;
  localparam int TILE_ADDR_W = ROW_W + COL_W;
  localparam int TILE_DEPTH  = TILE_ROWS * TILE_COLS;

  // First and last counter value of a sync pulse
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int H_SYNC_START_DEF = sync_start(H_ACTIVE_DEF, H_FP_DEF);              // 656
  localparam int H_SYNC_END_DEF   = sync_end(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);    // 751
  localparam int V_SYNC_START_DEF = sync_start(V_ACTIVE_DEF, V_FP_DEF);              // 490
  localparam int V_SYNC_END_DEF   = sync_end(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);    // 491

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_tile_display_if.sv
// vga_tile_display_if: tile write bus from the AHB-lite VGA slave.
interface vga_tile_display_if;
  import vga_pkg::*;

  logic [ROW_W-1:0] vga_addr_v;
  logic [COL_W-1:0] vga_addr_h;
  logic [31:0]      vga_ctrl;
  logic             vga_ctrl_en;

  modport master (output vga_addr_v, output vga_addr_h, output vga_ctrl, output vga_ctrl_en);
  modport slave  (input  vga_addr_v, input  vga_addr_h, input  vga_ctrl, input  vga_ctrl_en);
endinterface

// File: rtl/vga_tile_ram.sv
// vga_tile_ram: 512x12 simple dual-port tile buffer, synchronous write and
// synchronous read; a same-address read-during-write returns the old word.
module vga_tile_ram
  import vga_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [TILE_ADDR_W-1:0] waddr_i,
  input  logic [11:0]            wdata_i,
  input  logic                   re_i,
  input  logic [TILE_ADDR_W-1:0] raddr_i,
  output logic [11:0]            rdata_o
);

  logic [11:0] mem [TILE_DEPTH];
  logic [11:0] rdata_q;

  // Write port: tile colours survive reset.
  // NOTE: the array has no reset branch so it maps onto block RAM; its
  // contents must persist across HRESET anyway.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: the non-blocking read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_tile_display.sv
// vga_tile_display: VGA timing generator that scans a 16x32 tile colour buffer
// out as CELL_W x CELL_H pixel tiles, with a 2-tick counter-to-pin pipeline.
// Optional feature macro VGA_CURSOR_EN: blinking inverted cursor tile at the
// address of the most recent write (64-frame blink period).
module vga_tile_display
  import vga_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CELL_W   = CELL_W_DEF,
  parameter int CELL_H   = CELL_H_DEF
) (
  input  logic              HCLK,
  input  logic              HRESET,
  vga_tile_display_if.slave bus,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0]  HS_FIRST = HW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [HW-1:0]  HS_LAST  = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [VW-1:0]  VS_FIRST = VW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [VW-1:0]  VS_LAST  = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [SXW-1:0] SX_LAST  = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SY_LAST  = SYW'(CELL_H - 1);

  // Stage 0: divider, raster counters and tile indices
  logic [DW-1:0]    div_q, div_d;
  logic             pix_en;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [SXW-1:0]   sx_q, sx_d;
  logic [SYW-1:0]   sy_q, sy_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_start_q, frame_start_d;

  // Stage 1 / stage 2
  logic             act1_q, hs1_q, vs1_q;
  logic             hs2_q, vs2_q;
  rgb444_t          rgb_q, rgb_d;
  logic [11:0]      rd_data, pix_d;
  logic             invert;
  logic             unused_ctrl_hi;

  assign unused_ctrl_hi = ^bus.vga_ctrl[31:12];

  assign pix_en = (div_q == DIV_LAST);
  assign div_d  = pix_en ? '0 : div_q + DW'(1);
  assign frame_start_d = pix_en && (h_q == H_LAST) && (v_q == V_LAST);

  // Next raster position; tile indices restart on each counter wrap.
  // NOTE: every always_comb output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    h_d = h_q;  v_d = v_q;  sx_d = sx_q;  sy_d = sy_q;  col_d = col_q;  row_d = row_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;  sx_d = '0;  col_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;  sy_d = '0;  row_d = '0;
        end else begin
          v_d = v_q + VW'(1);
          if (sy_q == SY_LAST) begin
            sy_d  = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            sy_d = sy_q + SYW'(1);
          end
        end
      end else begin
        h_d = h_q + HW'(1);
        if (sx_q == SX_LAST) begin
          sx_d  = '0;
          col_d = col_q + COL_W'(1);
        end else begin
          sx_d = sx_q + SXW'(1);
        end
      end
    end
  end

  // Stage 0 register: divider, counters and the frame_start pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_q <= '0;  h_q <= '0;  v_q <= '0;  sx_q <= '0;  sy_q <= '0;
      col_q <= '0;  row_q <= '0;  frame_start_q <= 1'b0;
    end else begin
      div_q <= div_d;  h_q <= h_d;  v_q <= v_d;  sx_q <= sx_d;  sy_q <= sy_d;
      col_q <= col_d;  row_q <= row_d;  frame_start_q <= frame_start_d;
    end
  end

  vga_tile_ram u_ram (
    .clk     (HCLK),
    .rst     (HRESET),
    .we_i    (bus.vga_ctrl_en),
    .waddr_i ({bus.vga_addr_v, bus.vga_addr_h}),
    .wdata_i (bus.vga_ctrl[11:0]),
    .re_i    (pix_en),
    .raddr_i ({row_q, col_q}),
    .rdata_o (rd_data)
  );

`ifdef VGA_CURSOR_EN
  logic [TILE_ADDR_W-1:0] cursor_q;
  logic [5:0]             frame_cnt_q;
  logic                   hit1_q;

  // Cursor follows the last write; frame counter drives the blink; hit tracks stage 1.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cursor_q <= '0;  frame_cnt_q <= '0;  hit1_q <= 1'b0;
    end else begin
      if (bus.vga_ctrl_en) cursor_q <= {bus.vga_addr_v, bus.vga_addr_h};
      if (frame_start_q)   frame_cnt_q <= frame_cnt_q + 6'd1;
      if (pix_en)          hit1_q <= ({row_q, col_q} == cursor_q);
    end
  end

  assign invert = hit1_q & frame_cnt_q[5];
`else
  assign invert = 1'b0;
`endif

  // Output colour: optional cursor inversion, blanked outside the active area.
  always_comb begin
    pix_d = rd_data;
    if (invert) pix_d = ~rd_data;
    rgb_d = act1_q ? rgb444_t'(pix_d) : '0;
  end

  // Stages 1 and 2: delay active/sync alongside the RAM read, then register pins.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      act1_q <= 1'b0;  hs1_q <= 1'b1;  vs1_q <= 1'b1;
      hs2_q  <= 1'b1;  vs2_q <= 1'b1;  rgb_q <= '0;
    end else if (pix_en) begin
      act1_q <= (h_q < H_ACT) && (v_q < V_ACT);
      hs1_q  <= !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
      vs1_q  <= !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign vga_hsync   = hs2_q;
  assign vga_vsync   = vs2_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_tile_display.sv
// tb_vga_tile_display: directed bench for vga_tile_display. The raster is
// shrunk (2x2-pixel tiles, 72x36 total) so whole frames fit a short run while
// keeping the 16x32 tile array and PIX_DIV=2.
module tb_vga_tile_display;

  localparam int PIX_DIV = 2;
  localparam int H_ACT = 64, H_FP = 2, H_SY = 4, H_BP = 2;
  localparam int V_ACT = 32, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int LINE       = H_ACT + H_FP + H_SY + H_BP;  // 72 pixels
  localparam int LINES      = V_ACT + V_FP + V_SY + V_BP;  // 36 lines
  localparam int FRAME_PIX  = LINE * LINES;                // 2592
  localparam int FRAME_HCLK = FRAME_PIX * PIX_DIV;         // 5184
  localparam int HS_RUN     = H_SY * PIX_DIV;              // 8 HCLK
  localparam int VS_RUN     = V_SY * LINE * PIX_DIV;       // 288 HCLK

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       vga_hsync, vga_vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_tile_display_if bus ();

  vga_tile_display #(
    .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP), .CELL_W(2), .CELL_H(2)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .bus         (bus),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;
  int cyc;          // HCLK edges since the last edge that sampled HRESET=1
  bit measure_en = 1'b1;
  int hs_low [2];
  int vs_low [2];
  int hs_run, vs_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pins show pixel k after the 2nd pix_en tick beyond the counters: edge 2k+4.
  function automatic int cyc_of(input int f, input int x, input int y);
    return PIX_DIV * (f * FRAME_PIX + y * LINE + x) + 4;
  endfunction

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc != target && guard < 20000) begin
      @(negedge HCLK);
      guard++;
    end
    check("wait_cycle", cyc, target);
  endtask

  task automatic write_tile(input int v, input int h, input logic [31:0] d);
    bus.vga_addr_v  = 4'(v);
    bus.vga_addr_h  = 5'(h);
    bus.vga_ctrl    = d;
    bus.vga_ctrl_en = 1'b1;
    @(negedge HCLK);
    bus.vga_ctrl_en = 1'b0;
  endtask

  always @(posedge HCLK) begin
    if (HRESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // frame_start must pulse exactly on every FRAME_HCLK boundary after release.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (frame_start || (cyc > 0 && cyc % FRAME_HCLK == 0))
        check("frame_start", 32'(frame_start), 32'(cyc > 0 && cyc % FRAME_HCLK == 0));
    end
  end

  // Sync pulse widths and per-frame low counts for the first two frames.
  always @(negedge HCLK) begin
    if (HRESET) begin
      hs_run <= 0;
      vs_run <= 0;
    end else begin
      if (!vga_hsync) hs_run <= hs_run + 1;
      else if (hs_run != 0) begin
        check("hsync_width", hs_run, HS_RUN);
        hs_run <= 0;
      end
      if (!vga_vsync) vs_run <= vs_run + 1;
      else if (vs_run != 0) begin
        check("vsync_width", vs_run, VS_RUN);
        vs_run <= 0;
      end
      if (measure_en && cyc >= 4 && cyc < 4 + 2 * FRAME_HCLK) begin
        if (!vga_hsync) hs_low[(cyc - 4) / FRAME_HCLK] <= hs_low[(cyc - 4) / FRAME_HCLK] + 1;
        if (!vga_vsync) vs_low[(cyc - 4) / FRAME_HCLK] <= vs_low[(cyc - 4) / FRAME_HCLK] + 1;
      end
    end
  end

  typedef struct {
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // Frame-0 pixels in raster order: x, y, rgb, hsync, vsync
    vecs[0]  = '{0,  0,  12'hFFF, 1'b1, 1'b1};
    vecs[1]  = '{63, 0,  12'hFFF, 1'b1, 1'b1};
    vecs[2]  = '{64, 0,  12'h000, 1'b1, 1'b1};
    vecs[3]  = '{65, 0,  12'h000, 1'b1, 1'b1};
    vecs[4]  = '{66, 0,  12'h000, 1'b0, 1'b1};
    vecs[5]  = '{69, 0,  12'h000, 1'b0, 1'b1};
    vecs[6]  = '{70, 0,  12'h000, 1'b1, 1'b1};
    vecs[7]  = '{10, 5,  12'hFFF, 1'b1, 1'b1};
    vecs[8]  = '{9,  6,  12'hFFF, 1'b1, 1'b1};
    vecs[9]  = '{10, 6,  12'hF0A, 1'b1, 1'b1};
    vecs[10] = '{11, 6,  12'hF0A, 1'b1, 1'b1};
    vecs[11] = '{12, 6,  12'hFFF, 1'b1, 1'b1};
    vecs[12] = '{11, 7,  12'hF0A, 1'b1, 1'b1};
    vecs[13] = '{11, 8,  12'hFFF, 1'b1, 1'b1};
    vecs[14] = '{63, 31, 12'hFFF, 1'b1, 1'b1};
    vecs[15] = '{0,  32, 12'h000, 1'b1, 1'b1};
    vecs[16] = '{0,  33, 12'h000, 1'b1, 1'b0};
    vecs[17] = '{67, 34, 12'h000, 1'b0, 1'b0};
    vecs[18] = '{71, 34, 12'h000, 1'b1, 1'b0};
    vecs[19] = '{0,  35, 12'h000, 1'b1, 1'b1};

    HRESET = 1'b1;
    bus.vga_addr_v = '0;  bus.vga_addr_h = '0;  bus.vga_ctrl = '0;  bus.vga_ctrl_en = 1'b0;
    repeat (3) @(negedge HCLK);
    check("reset_hsync", 32'(vga_hsync), 32'd1);
    check("reset_vsync", 32'(vga_vsync), 32'd1);
    check("reset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
    check("reset_frame_start", 32'(frame_start), 32'd0);

    // Fill the buffer while held in reset, then one distinct tile; bits 31:12 ignored.
    for (int i = 0; i < 512; i++) begin
      bus.vga_addr_v  = 4'(i >> 5);
      bus.vga_addr_h  = 5'(i);
      bus.vga_ctrl    = 32'h0000_0FFF;
      bus.vga_ctrl_en = 1'b1;
      @(negedge HCLK);
    end
    bus.vga_ctrl_en = 1'b0;
    write_tile(3, 5, 32'h1234_5F0A);
    HRESET = 1'b0;

    for (int i = 0; i < 20; i++) begin
      wait_cyc(cyc_of(0, vecs[i].x, vecs[i].y));
      check($sformatf("rgb(%0d,%0d)", vecs[i].x, vecs[i].y), {20'd0, vga_r, vga_g, vga_b}, {20'd0, vecs[i].rgb});
      check($sformatf("hsync(%0d,%0d)", vecs[i].x, vecs[i].y), 32'(vga_hsync), 32'(vecs[i].hs));
      check($sformatf("vsync(%0d,%0d)", vecs[i].x, vecs[i].y), 32'(vga_vsync), 32'(vecs[i].vs));
    end

    // Tile (0,0)=0x111 after frame 1 has finished reading it.
    wait_cyc(cyc_of(1, 0, 10));
    write_tile(0, 0, 32'h0000_0111);

    // Collide a write with the read of pixel (0,0) of frame 2 (edge 2k+2).
    wait_cyc(cyc_of(2, 0, 0) - 3);
    write_tile(0, 0, 32'h0000_0222);

    wait_cyc(cyc_of(2, 0, 0));
    measure_en = 1'b0;
    check("hsync_low_frame0", hs_low[0], 36 * HS_RUN);
    check("hsync_low_frame1", hs_low[1], 36 * HS_RUN);
    check("vsync_low_frame0", vs_low[0], VS_RUN);
    check("vsync_low_frame1", vs_low[1], VS_RUN);
    check("rdw_old_data", {20'd0, vga_r, vga_g, vga_b}, 32'h111);
    wait_cyc(cyc_of(2, 1, 0));
    check("rdw_new_data", {20'd0, vga_r, vga_g, vga_b}, 32'h222);
    wait_cyc(cyc_of(2, 0, 1));
    check("rdw_new_data_row1", {20'd0, vga_r, vga_g, vga_b}, 32'h222);

    // Mid-frame reset inside the active area.
    wait_cyc(cyc_of(2, 10, 20));
    check("pre_reset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midreset_hsync", 32'(vga_hsync), 32'd1);
    check("midreset_vsync", 32'(vga_vsync), 32'd1);
    check("midreset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
    check("midreset_frame_start", 32'(frame_start), 32'd0);
    HRESET = 1'b0;

    wait_cyc(cyc_of(0, 1, 0));
    check("retained_0_0", {20'd0, vga_r, vga_g, vga_b}, 32'h222);
    wait_cyc(cyc_of(0, 10, 7));
    check("retained_3_5", {20'd0, vga_r, vga_g, vga_b}, 32'hF0A);
    wait_cyc(FRAME_HCLK);
    check("frame_start_after_reset", 32'(frame_start), 32'd1);
    wait_cyc(FRAME_HCLK + 1);
    check("frame_start_one_cycle", 32'(frame_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
